// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial wide subtractor sequencer: computes a - b - bin one 4-bit nibble
// per clock through an external 4-bit borrow-lookahead subtractor (bls_* ports).
// Result assembles LSB nibble first; start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches a, b, bin.
// busy is high for the NIBBLES RUN cycles; done pulses for one cycle afterwards,
// and result/bout/zero are valid from that cycle until the next accepted start.
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 bout,
    output logic                 zero,
    output logic [3:0]           bls_x,
    output logic [3:0]           bls_y,
    output logic                 bls_bin,
    input  logic [3:0]           bls_diff,
    input  logic                 bls_bout,
    output logic [1:0]           state_dbg
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_reg, b_reg;
    logic            borrow;
    logic            last;
    logic [W-1:0]    res_next;

    assign last      = (cnt == CW'(NIBBLES - 1));
    assign busy      = (state == RUN);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode; the counter guards the RUN exit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drive the downstream subtractor from the latched operands; quiet outside RUN.
    // The borrow register is preloaded with bin, so nibble 0 sees the latched bin.
    always_comb begin
        bls_x   = 4'd0;
        bls_y   = 4'd0;
        bls_bin = 1'b0;
        if (state == RUN) begin
            bls_x   = a_reg[4*int'(cnt) +: 4];
            bls_y   = b_reg[4*int'(cnt) +: 4];
            bls_bin = borrow;
        end
    end

    // Result with the current nibble merged in, used for the zero flag on the last step.
    always_comb begin
        res_next = result;
        res_next[4*int'(cnt) +: 4] = bls_diff;
    end

    // Datapath: operand latch, nibble write-back, borrow chain and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    result <= res_next;
                    borrow <= bls_bout;
                    if (last) begin
                        done <= 1'b1;
                        bout <= bls_bout;
                        zero <= (res_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor with a behavioural 4-bit
// borrow subtractor attached to the bls_* ports.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, zero;
    logic [15:0] result;
    logic [3:0]  bls_x, bls_y, bls_diff;
    logic        bls_bin, bls_bout;
    logic [1:0]  state_dbg;
    logic [4:0]  bls_sum;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    // downstream 4-bit subtractor: Diff/Bout from X - Y - Bin
    assign bls_sum  = {1'b0, bls_x} - {1'b0, bls_y} - {4'b0, bls_bin};
    assign bls_diff = bls_sum[3:0];
    assign bls_bout = bls_sum[4];

    nibble_serial_subtractor #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .result(result), .bout(bout), .zero(zero),
        .bls_x(bls_x), .bls_y(bls_y), .bls_bin(bls_bin),
        .bls_diff(bls_diff), .bls_bout(bls_bout), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns at the negedge of RUN cycle 1.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask

    // Full operation: latency from start, results, one-cycle done; bls_bin per RUN cycle.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic [15:0] exp_r, input logic exp_bo,
                          input logic exp_z, output logic [3:0] bin_seen);
        int lat;
        bin_seen = '0;
        start_op(ta, tb_v, tbin);
        lat = 1;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        bin_seen[0] = bls_bin;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat <= 4) bin_seen[lat-1] = bls_bin;
        end
        check({tag, ".latency"}, 32'(lat), 32'd5);
        check({tag, ".result"}, 32'(result), 32'(exp_r));
        check({tag, ".bout"}, 32'(bout), 32'(exp_bo));
        check({tag, ".zero"}, 32'(zero), 32'(exp_z));
        @(negedge clk);
        check({tag, ".done_once"}, 32'(done), 32'd0);
    endtask

    // directed sequence, scoreboard-free since every expectation is hand-computed
    initial begin : main
        logic [3:0]  bs;
        logic [16:0] e;
        logic [15:0] ra, rb;
        logic        rbin;
        int          ndone;

        // reset state
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.bout_zero", {30'd0, bout, zero}, 32'd0);
        check("rst.bls", {23'd0, bls_x, bls_y, bls_bin}, 32'd0);
        check("rst.state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        // T1 plus operand routing in RUN cycle 1
        @(negedge clk);
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hFFFF; b = 16'h0000;
        check("t1.bls_x0", 32'(bls_x), 32'h4);
        check("t1.bls_y0", 32'(bls_y), 32'h4);
        repeat (8) @(negedge clk);
        check("t1.idle_bls", {23'd0, bls_x, bls_y, bls_bin}, 32'd0);
        run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, bs);

        // T2: borrow ripples through nibbles 1..3
        run_op("t2", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, bs);
        check("t2.bls_bin", 32'(bs), 32'b1110);

        // T3
        run_op("t3a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, bs);
        run_op("t3b", 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b0, bs);
        check("t3b.bls_bin0", 32'(bs[0]), 32'd1);

        // T4
        run_op("t4a", 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, bs);
        run_op("t4b", 16'hA5A5, 16'hA5A5, 1'b1, 16'hFFFF, 1'b1, 1'b0, bs);

        // T5: second start during RUN is ignored
        ndone = 0;
        start_op(16'h1234, 16'h0234, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("t5.done_count", 32'(ndone), 32'd1);
        check("t5.result", 32'(result), 32'h1000);
        check("t5.idle", 32'(busy), 32'd0);

        // T6: reset in RUN cycle 3 aborts the operation
        start_op(16'h1234, 16'h0234, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.result", 32'(result), 32'd0);
        check("t6.done", 32'(done), 32'd0);
        check("t6.bls_x", 32'(bls_x), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6.no_done", 32'(ndone), 32'd0);
        run_op("t6.after", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, bs);

        // random operations against {bout,result} = {0,a} - b - bin
        for (int i = 0; i < 200; i++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rbin = 1'($urandom_range(0, 1));
            if (i % 16 == 0) rb = ra;
            e = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            run_op("rand", ra, rb, rbin, e[15:0], e[16], (e[15:0] == 16'd0), bs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
